// File: rtl/rfarb_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package rfarb_pkg;

  localparam int DEF_DW = 32;
  localparam int DEF_AW = 5;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  typedef struct packed {
    logic [DEF_AW-1:0] regAddr;
    logic [DEF_DW-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO holding writeback entries; exposes its live entries
// so the parent can decode which registers still have a write queued.
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int DW    = 32,
  parameter int AW    = 5
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       push,
  input  logic [AW-1:0]              pushReg,
  input  logic [DW-1:0]              pushData,
  input  logic                       pop,
  output logic [AW-1:0]              headReg,
  output logic [DW-1:0]              headData,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full,
  output logic [DEPTH-1:0]           validMask,
  output logic [DEPTH-1:0][AW-1:0]   entryReg
);

  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0][AW-1:0] regMem;
  logic [DW-1:0]            dataMem [DEPTH];
  logic [PW-1:0]            rdPtr;
  logic [PW-1:0]            wrPtr;
  logic [PW-1:0]            offset;
  logic                     doPush;
  logic                     doPop;

  assign empty    = (count == '0);
  assign full     = (count == (PW+1)'(DEPTH));
  assign doPush   = push && !full;
  assign doPop    = pop && !empty;
  assign headReg  = regMem[rdPtr];
  assign headData = dataMem[rdPtr];
  assign entryReg = regMem;

  always_ff @(posedge CLK) begin
    if (RST) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) begin
        regMem[wrPtr]  <= pushReg;
        dataMem[wrPtr] <= pushData;
        wrPtr          <= wrPtr + 1'b1;
      end
      if (doPop) begin
        rdPtr <= rdPtr + 1'b1;
      end
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A slot is live when its distance from the read pointer is below the count.
  always_comb begin
    offset    = '0;
    validMask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset       = PW'(i) - rdPtr;
      validMask[i] = ({1'b0, offset} < count);
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between ALU (A) and load (B) writebacks.
// Define RFARB_STRICT_PRIO_EN to make A always win contention instead of round-robin.
module regfile_wb_arbiter
  import rfarb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int DW    = DEF_DW,
  parameter int AW    = DEF_AW
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [AW-1:0]     a_reg,
  input  logic [DW-1:0]     a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [AW-1:0]     b_reg,
  input  logic [DW-1:0]     b_data,
  output logic              RegWre,
  output logic [AW-1:0]     WriteReg,
  output logic [DW-1:0]     WriteData,
  output logic [2**AW-1:0]  pending,
  output logic              idle
);

  logic [AW-1:0]              aHeadReg, bHeadReg;
  logic [DW-1:0]              aHeadData, bHeadData;
  logic [$clog2(DEPTH):0]     aCount, bCount;
  logic                       aEmpty, bEmpty;
  logic                       aFull, bFull;
  logic [DEPTH-1:0]           aValidMask, bValidMask;
  logic [DEPTH-1:0][AW-1:0]   aEntryReg, bEntryReg;
  logic                       grantA, grantB;

  assign a_ready = !aFull;
  assign b_ready = !bFull;

  wb_fifo #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) fifoA (
    .CLK(CLK), .RST(RST),
    .push(a_valid && a_ready), .pushReg(a_reg), .pushData(a_data),
    .pop(grantA), .headReg(aHeadReg), .headData(aHeadData),
    .count(aCount), .empty(aEmpty), .full(aFull),
    .validMask(aValidMask), .entryReg(aEntryReg)
  );

  wb_fifo #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) fifoB (
    .CLK(CLK), .RST(RST),
    .push(b_valid && b_ready), .pushReg(b_reg), .pushData(b_data),
    .pop(grantB), .headReg(bHeadReg), .headData(bHeadData),
    .count(bCount), .empty(bEmpty), .full(bFull),
    .validMask(bValidMask), .entryReg(bEntryReg)
  );

`ifdef RFARB_STRICT_PRIO_EN
  always_comb begin
    grantA = !aEmpty;
    grantB = aEmpty && !bEmpty;
  end
`else
  logic lastGrant;

  // Under contention the requester that did not win last time gets the port.
  always_comb begin
    grantA = 1'b0;
    grantB = 1'b0;
    if (!aEmpty && !bEmpty) begin
      grantA = (lastGrant == REQ_B);
      grantB = !grantA;
    end else begin
      grantA = !aEmpty;
      grantB = !bEmpty;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      lastGrant <= REQ_B;
    end else if (grantA || grantB) begin
      lastGrant <= grantA ? REQ_A : REQ_B;
    end
  end
`endif

  // Register zero is architecturally constant, so its entries drain without a strobe.
  always_ff @(posedge CLK) begin
    if (RST) begin
      RegWre    <= 1'b0;
      WriteReg  <= '0;
      WriteData <= '0;
    end else if (grantA) begin
      RegWre    <= (aHeadReg != '0);
      WriteReg  <= aHeadReg;
      WriteData <= aHeadData;
    end else if (grantB) begin
      RegWre    <= (bHeadReg != '0);
      WriteReg  <= bHeadReg;
      WriteData <= bHeadData;
    end else begin
      RegWre    <= 1'b0;
    end
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (aValidMask[i]) pending[aEntryReg[i]] = 1'b1;
      if (bValidMask[i]) pending[bEntryReg[i]] = 1'b1;
    end
    pending[0] = 1'b0;
  end

  assign idle = (aCount == '0) && (bCount == '0) && !RegWre;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: expected writes are queued as stimulus
// is driven and compared against every RegWre strobe seen at the falling edge.
module tb_regfile_wb_arbiter;
  import rfarb_pkg::*;

  localparam int DEPTH = 2;
  localparam int DW    = 32;
  localparam int AW    = 5;

  logic              CLK = 1'b0;
  logic              RST;
  logic              a_valid, b_valid;
  logic              a_ready, b_ready;
  logic [AW-1:0]     a_reg, b_reg;
  logic [DW-1:0]     a_data, b_data;
  logic              RegWre;
  logic [AW-1:0]     WriteReg;
  logic [DW-1:0]     WriteData;
  logic [2**AW-1:0]  pending;
  logic              idle;

  int        testsRun    = 0;
  int        testsFailed = 0;
  wb_entry_t expQ[$];

  regfile_wb_arbiter #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
    .CLK(CLK), .RST(RST),
    .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
    .RegWre(RegWre), .WriteReg(WriteReg), .WriteData(WriteData),
    .pending(pending), .idle(idle)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic expectWrite(input logic [AW-1:0] r, input logic [DW-1:0] d);
    expQ.push_back('{regAddr: r, data: d});
  endtask

  // Holds valid until the handshake completes; returns #1 after the accepting edge.
  task automatic applyStimulus(input bit sideB, input logic [AW-1:0] r, input logic [DW-1:0] d);
    bit accepted = 1'b0;
    if (sideB) begin b_valid = 1'b1; b_reg = r; b_data = d; end
    else       begin a_valid = 1'b1; a_reg = r; a_data = d; end
    for (int n = 0; n < 50 && !accepted; n++) begin
      accepted = sideB ? b_ready : a_ready;
      @(posedge CLK);
    end
    #1;
    if (!accepted) checkOutput(sideB ? "pushTimeoutB" : "pushTimeoutA", 64'(accepted), 64'd1);
    if (sideB) b_valid = 1'b0;
    else       a_valid = 1'b0;
  endtask

  task automatic doReset();
    RST = 1'b1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  always @(negedge CLK) begin
    if (RegWre === 1'b1) begin
      checkOutput("wrExpected", 64'(expQ.size() != 0), 64'd1);
      if (expQ.size() != 0) begin
        wb_entry_t e;
        e = expQ.pop_front();
        checkOutput("wrReg", 64'(WriteReg), 64'(e.regAddr));
        checkOutput("wrData", 64'(WriteData), 64'(e.data));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int runLen;
    int waitN;
    RST = 1'b1;
    a_valid = 1'b0; a_reg = '0; a_data = '0;
    b_valid = 1'b0; b_reg = '0; b_data = '0;
    doReset();

    checkOutput("rstRegWre", 64'(RegWre), 64'd0);
    checkOutput("rstWriteReg", 64'(WriteReg), 64'd0);
    checkOutput("rstWriteData", 64'(WriteData), 64'd0);
    checkOutput("rstReadyA", 64'(a_ready), 64'd1);
    checkOutput("rstReadyB", 64'(b_ready), 64'd1);
    checkOutput("rstPending", 64'(pending), 64'd0);
    checkOutput("rstIdle", 64'(idle), 64'd1);

    // Reset while A still holds queued writes to regs 3 and 4.
`ifdef RFARB_STRICT_PRIO_EN
    a_valid = 1'b1; a_reg = 5'd3; a_data = 32'h33;
    tick();
    checkOutput("midPend", 64'(pending), 64'h8);
`else
    expectWrite(5'd7, 32'h77);
    expectWrite(5'd10, 32'h1010);
    a_valid = 1'b1; a_reg = 5'd7; a_data = 32'h77;
    tick();
    a_reg = 5'd3; a_data = 32'h33;
    b_valid = 1'b1; b_reg = 5'd10; b_data = 32'h1010;
    tick();
    a_reg = 5'd4; a_data = 32'h44;
    b_valid = 1'b0;
    tick();
    checkOutput("midFullA", 64'(a_ready), 64'd0);
    checkOutput("midPend", 64'(pending), 64'h18);
`endif
    a_valid = 1'b0;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    checkOutput("midRegWre", 64'(RegWre), 64'd0);
    checkOutput("midPendClr", 64'(pending), 64'd0);
    checkOutput("midReadyA", 64'(a_ready), 64'd1);
    checkOutput("midIdle", 64'(idle), 64'd1);
    repeat (5) tick();
    checkOutput("midDrain", 64'(expQ.size()), 64'd0);

    // Single write and its one-cycle pending window.
    expectWrite(5'd5, 32'hDEADBEEF);
    applyStimulus(1'b0, 5'd5, 32'hDEADBEEF);
    checkOutput("singlePend", 64'(pending), 64'h20);
    checkOutput("singleEarly", 64'(RegWre), 64'd0);
    checkOutput("singleBusy", 64'(idle), 64'd0);
    tick();
    checkOutput("singleWre", 64'(RegWre), 64'd1);
    checkOutput("singleReg", 64'(WriteReg), 64'd5);
    checkOutput("singleData", 64'(WriteData), 64'hDEADBEEF);
    checkOutput("singlePendClr", 64'(pending), 64'd0);
    tick();
    checkOutput("singleDone", 64'(RegWre), 64'd0);
    checkOutput("singleHold", 64'(WriteReg), 64'd5);
    checkOutput("singleIdle", 64'(idle), 64'd1);

    // Contention between two preloaded entries per side.
    doReset();
    expectWrite(5'd1, 32'h11);
`ifdef RFARB_STRICT_PRIO_EN
    expectWrite(5'd2, 32'h22);
    expectWrite(5'd3, 32'h33);
`else
    expectWrite(5'd3, 32'h33);
    expectWrite(5'd2, 32'h22);
`endif
    expectWrite(5'd4, 32'h44);
    fork
      applyStimulus(1'b0, 5'd1, 32'h11);
      applyStimulus(1'b1, 5'd3, 32'h33);
    join
    fork
      applyStimulus(1'b0, 5'd2, 32'h22);
      applyStimulus(1'b1, 5'd4, 32'h44);
    join
    repeat (4) tick();
    checkOutput("contDrain", 64'(expQ.size()), 64'd0);

`ifndef RFARB_STRICT_PRIO_EN
    // Backpressure: A fills while B takes a turn, then frees a slot without a same-edge push.
    doReset();
    expectWrite(5'd9, 32'h99);
    expectWrite(5'd20, 32'h20);
    expectWrite(5'd21, 32'h21);
    expectWrite(5'd23, 32'h23);
    expectWrite(5'd22, 32'h22);
    expectWrite(5'd24, 32'h24);
    a_valid = 1'b1; a_reg = 5'd9; a_data = 32'h99;
    tick();
    checkOutput("fullRdy1", 64'(a_ready), 64'd1);
    a_reg = 5'd21; a_data = 32'h21;
    b_valid = 1'b1; b_reg = 5'd20; b_data = 32'h20;
    tick();
    a_reg = 5'd22; a_data = 32'h22;
    b_reg = 5'd23; b_data = 32'h23;
    tick();
    checkOutput("fullRdy0", 64'(a_ready), 64'd0);
    a_reg = 5'd24; a_data = 32'h24;
    b_valid = 1'b0;
    tick();
    checkOutput("fullRdyBack", 64'(a_ready), 64'd1);
    checkOutput("fullNoPush", 64'(pending), 64'h00C0_0000);
    tick();
    a_valid = 1'b0;
    repeat (3) tick();
    checkOutput("fullDrain", 64'(expQ.size()), 64'd0);
`endif

    // Register zero entries drain silently but still load the output register.
    doReset();
    applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF);
    checkOutput("zeroPend", 64'(pending), 64'd0);
    checkOutput("zeroBusy", 64'(idle), 64'd0);
    tick();
    checkOutput("zeroWre", 64'(RegWre), 64'd0);
    checkOutput("zeroData", 64'(WriteData), 64'hFFFFFFFF);
    checkOutput("zeroPendAfter", 64'(pending), 64'd0);
    checkOutput("zeroIdle", 64'(idle), 64'd1);

    // Throughput: 8 writes per side back-to-back, expecting 16 strobes without a bubble.
    doReset();
`ifdef RFARB_STRICT_PRIO_EN
    for (int i = 0; i < 8; i++) expectWrite(5'(1 + i), 32'hA000_0000 + 32'(i));
    for (int i = 0; i < 8; i++) expectWrite(5'(9 + i), 32'hB000_0000 + 32'(i));
`else
    for (int i = 0; i < 8; i++) begin
      expectWrite(5'(1 + i), 32'hA000_0000 + 32'(i));
      expectWrite(5'(9 + i), 32'hB000_0000 + 32'(i));
    end
`endif
    runLen = 0;
    waitN  = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 5'(1 + i), 32'hA000_0000 + 32'(i));
      end
      begin
        for (int j = 0; j < 8; j++) applyStimulus(1'b1, 5'(9 + j), 32'hB000_0000 + 32'(j));
      end
      begin
        while (RegWre !== 1'b1 && waitN < 40) begin
          @(negedge CLK);
          waitN++;
        end
        for (int k = 0; k < 16; k++) begin
          if (RegWre === 1'b1) runLen++;
          @(negedge CLK);
        end
        checkOutput("thruRun", 64'(runLen), 64'd16);
        checkOutput("thruAfter", 64'(RegWre), 64'd0);
      end
    join
    repeat (2) tick();
    checkOutput("thruDrain", 64'(expQ.size()), 64'd0);
    checkOutput("thruIdle", 64'(idle), 64'd1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
